// File: rtl/my_seq_fsm_if.sv
// Switch/display bundle for the sequence FSM: the switch code goes in, and the
// state, event pulses and 7-segment digit drive come out.
interface my_seq_fsm_if #(
  parameter int SW_W = 2
);
  logic [SW_W-1:0] sw;
  logic [SW_W-1:0] state;
  logic            done;
  logic            tout;
  logic [6:0]      an;
  logic            ca;

  modport master (output sw, input state, done, tout, an, ca);
  modport slave  (input sw, output state, done, tout, an, ca);
endinterface

// File: rtl/my_seq_fsm.sv
// Switch-driven step sequencer. The state index advances when the switches
// show the next index, and can optionally step back or time out to idle.
// The state is shown in hex on a two-digit multiplexed 7-segment display.
module my_seq_fsm #(
  parameter int SW_W      = 2,
  parameter int NUM_STEPS = 4,
  parameter int SCAN_DIV  = 1_250_000,
  parameter int TIMEOUT   = 0,
  parameter int BACK_EN   = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  my_seq_fsm_if.slave   bus
);
  localparam int              SCW       = (SCAN_DIV < 1) ? 1 : $clog2(SCAN_DIV + 1);
  localparam logic [SW_W-1:0] LAST      = SW_W'(NUM_STEPS - 1);
  localparam logic [SCW-1:0]  SCAN_LAST = SCW'(SCAN_DIV);

  logic [SW_W-1:0] s, s_nxt, s_inc, s_dec;
  logic            adv, back, tmo, tmo_hit, done_nxt;
  logic            done_q, tout_q;
  logic [SCW-1:0]  scan;
  logic            ca;
  logic [7:0]      st8;
  logic [3:0]      nib;
  logic [6:0]      an;

  // State register; DONE is registered alongside it so it lands one cycle after the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s      <= '0;
      done_q <= 1'b0;
    end else begin
      s      <= s_nxt;
      done_q <= done_nxt;
    end
  end

  // Next-state: advance beats back, back beats timeout, anything else holds.
  always_comb begin
    s_nxt    = s;
    done_nxt = 1'b0;
    s_inc    = (s == LAST) ? '0 : s + SW_W'(1);
    s_dec    = s - SW_W'(1);
    adv      = (bus.sw == s_inc);
    back     = (BACK_EN != 0) && (s != '0) && !adv && (bus.sw == s_dec);
    tmo      = (TIMEOUT != 0) && (s != '0) && !adv && !back && tmo_hit;
    if (adv) begin
      s_nxt    = s_inc;
      done_nxt = (s == LAST);
    end else if (back) begin
      s_nxt = s_dec;
    end else if (tmo) begin
      s_nxt = '0;
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_tmo
      localparam int             DW       = $clog2(TIMEOUT + 1);
      localparam logic [DW-1:0]  TMO_LAST = DW'(TIMEOUT - 1);
      logic [DW-1:0] dwell;

      // Dwell time in the current non-idle state; restarts on every state change.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        dwell <= '0;
        else if (s_nxt != s || s == '0)    dwell <= '0;
        else if (dwell != '1)              dwell <= dwell + DW'(1);
      end

      // Timeout pulse, registered so it coincides with the return to idle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tout_q <= 1'b0;
        else        tout_q <= tmo;
      end

      assign tmo_hit = (dwell == TMO_LAST);
    end else begin : g_no_tmo
      assign tmo_hit = 1'b0;
      assign tout_q  = 1'b0;
    end
  endgenerate

  // Digit scan: SCAN_DIV+1 cycles per digit, then flip to the other nibble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan <= '0;
      ca   <= 1'b0;
    end else if (scan == SCAN_LAST) begin
      scan <= '0;
      ca   <= ~ca;
    end else begin
      scan <= scan + SCW'(1);
    end
  end

  // Segment decode straight off the state register so AN tracks STATE with no lag.
  always_comb begin
    st8 = 8'(s);
    nib = ca ? st8[7:4] : st8[3:0];
    an  = 7'h3F;
    case (nib)
      4'h0: an = 7'h3F;
      4'h1: an = 7'h06;
      4'h2: an = 7'h5B;
      4'h3: an = 7'h4F;
      4'h4: an = 7'h66;
      4'h5: an = 7'h6D;
      4'h6: an = 7'h7D;
      4'h7: an = 7'h07;
      4'h8: an = 7'h7F;
      4'h9: an = 7'h6F;
      4'hA: an = 7'h77;
      4'hB: an = 7'h7C;
      4'hC: an = 7'h39;
      4'hD: an = 7'h5E;
      4'hE: an = 7'h79;
      4'hF: an = 7'h71;
      default: an = 7'h3F;
    endcase
  end

  assign bus.state = s;
  assign bus.done  = done_q;
  assign bus.tout  = tout_q;
  assign bus.an    = an;
  assign bus.ca    = ca;
endmodule

// File: tb/tb_my_seq_fsm.sv
// Bench for my_seq_fsm: three instances share clock and reset
//   a: SW_W=2, 4 steps, no back, no timeout
//   b: SW_W=2, 4 steps, back enabled, TIMEOUT=5
//   c: SW_W=5, 20 steps (wide display)
module tb_my_seq_fsm;
  logic clk;
  logic rst_n;

  my_seq_fsm_if #(.SW_W(2)) ifa ();
  my_seq_fsm_if #(.SW_W(2)) ifb ();
  my_seq_fsm_if #(.SW_W(5)) ifc ();

  my_seq_fsm #(.SW_W(2), .NUM_STEPS(4), .SCAN_DIV(3), .TIMEOUT(0), .BACK_EN(0))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  my_seq_fsm #(.SW_W(2), .NUM_STEPS(4), .SCAN_DIV(3), .TIMEOUT(5), .BACK_EN(1))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  my_seq_fsm #(.SW_W(5), .NUM_STEPS(20), .SCAN_DIV(3), .TIMEOUT(0), .BACK_EN(0))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising edges seen since reset release; digit select is bit 2 (4 cycles per digit).
  int ecnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  logic [6:0] hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0] sw;
    logic [1:0] st;
    logic       done;
  } vec_t;

  vec_t vecs [16];

  initial begin
    // Full cycle with DONE, wrong codes in state 1, no back step when disabled.
    vecs[0]  = '{2'd1, 2'd1, 1'b0};
    vecs[1]  = '{2'd1, 2'd1, 1'b0};
    vecs[2]  = '{2'd2, 2'd2, 1'b0};
    vecs[3]  = '{2'd2, 2'd2, 1'b0};
    vecs[4]  = '{2'd3, 2'd3, 1'b0};
    vecs[5]  = '{2'd3, 2'd3, 1'b0};
    vecs[6]  = '{2'd0, 2'd0, 1'b1};
    vecs[7]  = '{2'd0, 2'd0, 1'b0};
    vecs[8]  = '{2'd1, 2'd1, 1'b0};
    vecs[9]  = '{2'd3, 2'd1, 1'b0};
    vecs[10] = '{2'd0, 2'd1, 1'b0};
    vecs[11] = '{2'd2, 2'd2, 1'b0};
    vecs[12] = '{2'd1, 2'd2, 1'b0};
    vecs[13] = '{2'd3, 2'd3, 1'b0};
    vecs[14] = '{2'd0, 2'd0, 1'b1};
    vecs[15] = '{2'd2, 2'd0, 1'b0};

    rst_n  = 1'b0;
    ifa.sw = '0;
    ifb.sw = '0;
    ifc.sw = '0;
    #12;
    chk("rst_state_a", 32'(ifa.state), 32'd0);
    chk("rst_done_a",  32'(ifa.done),  32'd0);
    chk("rst_tout_b",  32'(ifb.tout),  32'd0);
    chk("rst_ca_a",    32'(ifa.ca),    32'd0);
    chk("rst_an_a",    32'(ifa.an),    32'h3F);
    chk("rst_an_c",    32'(ifc.an),    32'h3F);
    #10;
    rst_n = 1'b1;

    // Table vectors on instance a
    for (int i = 0; i < 16; i++) begin
      ifa.sw = vecs[i].sw;
      tick();
      chk($sformatf("v%0d_state", i), 32'(ifa.state), 32'(vecs[i].st));
      chk($sformatf("v%0d_done", i),  32'(ifa.done),  32'(vecs[i].done));
      chk($sformatf("v%0d_tout", i),  32'(ifa.tout),  32'd0);
      chk($sformatf("v%0d_ca", i),    32'(ifa.ca),    32'(ecnt[2]));
      chk($sformatf("v%0d_an", i),    32'(ifa.an),
          ecnt[2] ? 32'h3F : 32'(hex_tbl[vecs[i].st]));
    end

    // Timeout on b: enter state 1, hold a code that matches no rule
    ifb.sw = 2'd1;
    tick();
    chk("tmo_entry", 32'(ifb.state), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("tmo_hold%0d_state", k), 32'(ifb.state), 32'd1);
      chk($sformatf("tmo_hold%0d_tout", k),  32'(ifb.tout),  32'd0);
    end
    tick();
    chk("tmo_fire_state", 32'(ifb.state), 32'd0);
    chk("tmo_fire_tout",  32'(ifb.tout),  32'd1);
    chk("tmo_fire_done",  32'(ifb.done),  32'd0);
    ifb.sw = 2'd0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("tmo_idle%0d_state", k), 32'(ifb.state), 32'd0);
      chk($sformatf("tmo_idle%0d_tout", k),  32'(ifb.tout),  32'd0);
    end

    // Back steps on b
    ifb.sw = 2'd1; tick(); chk("bk_s1", 32'(ifb.state), 32'd1);
    ifb.sw = 2'd2; tick(); chk("bk_s2", 32'(ifb.state), 32'd2);
    ifb.sw = 2'd1; tick(); chk("bk_2to1", 32'(ifb.state), 32'd1);
    chk("bk_2to1_done", 32'(ifb.done), 32'd0);
    ifb.sw = 2'd0; tick(); chk("bk_1to0", 32'(ifb.state), 32'd0);
    tick();
    chk("bk_1to0_done", 32'(ifb.done), 32'd0);
    chk("bk_1to0_tout", 32'(ifb.tout), 32'd0);

    // Wide mode on c: walk to 18 (0x12) and watch both digits
    for (int i = 1; i <= 18; i++) begin
      ifc.sw = 5'(i);
      tick();
    end
    chk("wide_state", 32'(ifc.state), 32'd18);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("wide%0d_state", k), 32'(ifc.state), 32'd18);
      chk($sformatf("wide%0d_ca", k),    32'(ifc.ca),    32'(ecnt[2]));
      chk($sformatf("wide%0d_an", k),    32'(ifc.an),    ecnt[2] ? 32'h06 : 32'h5B);
    end

    // Asynchronous reset on a while in state 3
    ifa.sw = 2'd1; tick();
    ifa.sw = 2'd2; tick();
    ifa.sw = 2'd3; tick();
    chk("ar_pre_state", 32'(ifa.state), 32'd3);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_state", 32'(ifa.state), 32'd0);
    chk("ar_an",    32'(ifa.an),    32'h3F);
    chk("ar_ca",    32'(ifa.ca),    32'd0);
    chk("ar_done",  32'(ifa.done),  32'd0);
    chk("ar_c_state", 32'(ifc.state), 32'd0);
    tick();
    chk("ar_hold_state", 32'(ifa.state), 32'd0);
    chk("ar_hold_done",  32'(ifa.done),  32'd0);
    #3;
    ifa.sw = 2'd1;
    rst_n  = 1'b1;
    #1;
    chk("ar_rel_state", 32'(ifa.state), 32'd0);
    tick();
    chk("ar_first_edge", 32'(ifa.state), 32'd1);
    chk("ar_first_an",   32'(ifa.an),    32'h06);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/my_seq_fsm.md
MY_SEQ_FSM -- requirements
Module: my_seq_fsm

Interface
REQ-001 The block SHALL have parameter SW_W, default 2, giving the switch input width (1..8).
REQ-002 The block SHALL have parameter NUM_STEPS, default 4, giving the number of FSM states, with 2 <= NUM_STEPS <= 2**SW_W.
REQ-003 The block SHALL have parameter SCAN_DIV, default 1_250_000, giving the digit-scan terminal count (10 ms at 125 MHz).
REQ-004 The block SHALL have parameter TIMEOUT, default 0, giving idle-timeout cycles; 0 disables the timeout.
REQ-005 The block SHALL have parameter BACK_EN, default 0; 1 enables backward stepping.
REQ-006 Port CLK: input, 1 bit, the single clock, rising edge.
REQ-007 Port RST_N: input, 1 bit, reset, asynchronous and active-low.
REQ-008 Port SW: input, SW_W bits, switch code, sampled on CLK.
REQ-009 Port STATE: output, SW_W bits, current state index 0..NUM_STEPS-1, where 0 is idle.
REQ-010 Port DONE: output, 1 bit, one-cycle pulse on wrap from the last state to idle.
REQ-011 Port TOUT: output, 1 bit, one-cycle pulse on a timeout return to idle.
REQ-012 Port AN: output, 7 bits, active-high segments, bit0=A ... bit6=G.
REQ-013 Port CA: output, 1 bit, digit select: 0 = low nibble digit, 1 = high nibble digit.

Function
REQ-014 The state s SHALL be held in a register that updates on the CLK rising edge; STATE SHALL equal s directly, with no added latency.
REQ-015 Advance rule: in state s, if SW == (s+1) mod NUM_STEPS, the next state SHALL be (s+1) mod NUM_STEPS.
REQ-016 Back rule: if BACK_EN=1, s>0 and the advance rule does not apply, then SW == s-1 SHALL give next state s-1.
REQ-017 Priority: advance over back over timeout over hold; a state with no applicable rule SHALL hold.
REQ-018 Any SW code not named in REQ-015/016 SHALL hold the state and SHALL NOT be an error.
REQ-019 DONE SHALL be a registered output, asserted for exactly the one cycle following a NUM_STEPS-1 -> 0 advance; a back step or timeout SHALL NOT assert DONE.
REQ-020 Dwell counter: it SHALL clear on any state change and while s == 0, and otherwise increment by 1 per cycle, saturating.
REQ-021 When TIMEOUT > 0, s != 0, no advance/back applies and the dwell counter equals TIMEOUT-1, the next state SHALL be 0 and TOUT SHALL pulse for one cycle (registered).
REQ-022 With TIMEOUT = 0, the dwell counter SHALL be optimised away and TOUT SHALL be tied to 0.
REQ-023 Scan counter: it SHALL count 0..SCAN_DIV; at SCAN_DIV it SHALL wrap to 0 and toggle CA, giving a period of SCAN_DIV+1 cycles per digit.
REQ-024 AN SHALL be combinational, decoding the nibble selected by CA: CA=0 selects STATE[3:0], CA=1 selects STATE[7:4], with unused high bits zero-extended.
REQ-025 Hex decode for digits 0-F SHALL be: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
REQ-026 The FSM SHALL be independent of the scan logic; a state change SHALL be reflected on AN in the same cycle that STATE changes.

Reset
REQ-027 While RST_N=0, regardless of CLK: s=0, DONE=0, TOUT=0, CA=0, scan counter=0, dwell counter=0, AN=7'h3F.
REQ-028 Reset asserted mid-sequence SHALL return s to 0 immediately and SHALL NOT assert DONE or TOUT.
REQ-029 On RST_N deassertion, the first state evaluation SHALL occur at the next CLK rising edge.

Verification (sim parameters: SCAN_DIV=3, NUM_STEPS=4, SW_W=2 unless stated)
REQ-030 Full cycle: SW=1,2,3,0, each held for 2 cycles -> STATE 1,2,3,0; DONE high exactly 1 cycle after 3->0; AN shows 06,5B,4F,3F while CA=0.
REQ-031 Wrong codes: in state 1 apply SW=3, then SW=0 -> STATE stays 1; DONE=0, TOUT=0.
REQ-032 Back step with BACK_EN=1: in state 2 apply SW=1 -> STATE=1; with BACK_EN=0 the same stimulus -> STATE stays 2.
REQ-033 Timeout with TIMEOUT=5: enter state 1, hold SW=1 -> STATE returns to 0 exactly 5 cycles after entry; TOUT pulses once; holding in state 0 produces no further pulse.
REQ-034 Scan and wide mode with SW_W=5, NUM_STEPS=20: drive to state 18 (0x12) -> CA toggles every 4 cycles; AN=5B when CA=0 and 06 when CA=1.
REQ-035 Asynchronous reset: assert RST_N=0 between clock edges while in state 3 -> STATE=0, AN=3F and CA=0 before the next edge; no DONE pulse.
